// File: rtl/rifl_rx_frame_checker.sv
// RIFL RX frame checker: accumulates beats into frames, checks the frame-ID-salted CRC,
// tracks expected/threshold frame IDs with rollback and issues retransmission requests.
module rifl_rx_frame_checker #(
  parameter int unsigned                 FRAME_WIDTH    = 256,
  parameter int unsigned                 DWIDTH         = 64,
  parameter int unsigned                 CRC_WIDTH      = 12,
  parameter logic [CRC_WIDTH-1:0]        CRC_POLY       = 12'h02F,
  parameter int unsigned                 FRAME_ID_WIDTH = 8,
  parameter int unsigned                 ROLLBACK       = 16,
  parameter int unsigned                 CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      data_vld,
  input  logic                      sof,
  input  logic [DWIDTH-1:0]         data_in,
  output logic                      frame_done,
  output logic                      frame_isdata,
  output logic                      frame_good,
  output logic                      rx_error,
  output logic                      retrans_req,
  output logic [FRAME_ID_WIDTH-1:0] retrans_id,
  output logic [CNT_WIDTH-1:0]      good_cnt,
  output logic [CNT_WIDTH-1:0]      err_cnt,
  output logic [CNT_WIDTH-1:0]      abort_cnt
);

  localparam int unsigned Beats = FRAME_WIDTH / DWIDTH;
  localparam int unsigned BcW   = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [BcW-1:0]            LastBeat = BcW'(Beats - 1);
  localparam logic [FRAME_ID_WIDTH-1:0] Rollback = FRAME_ID_WIDTH'(ROLLBACK);

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e                    state_q;
  logic [BcW-1:0]            beat_cnt_q;
  logic [CRC_WIDTH-1:0]      crc_q;
  logic [1:0]                hdr_q;
  logic [FRAME_ID_WIDTH-1:0] frame_id_q;
  logic [FRAME_ID_WIDTH-1:0] thresh_q;

  logic                      at_last;
  logic                      complete;
  logic [CRC_WIDTH-1:0]      crc_nxt;
  logic [1:0]                hdr_cur;
  logic                      crc_ok;
  logic [FRAME_ID_WIDTH-1:0] rollback_id;

  // Bit-serial MSB-first CRC over one beat; on the last beat the CRC field itself reads as 0.
  function automatic logic [CRC_WIDTH-1:0] crc_beat(input logic [CRC_WIDTH-1:0] seed,
                                                    input logic [DWIDTH-1:0]    beat,
                                                    input logic                 last);
    logic [CRC_WIDTH-1:0] crc;
    logic                 b;
    logic                 fb;
    crc = seed;
    for (int i = DWIDTH - 1; i >= 0; i--) begin
      b   = beat[i] & ~(last && (i < int'(CRC_WIDTH)));
      fb  = crc[CRC_WIDTH-1] ^ b;
      crc = {crc[CRC_WIDTH-2:0], fb} ^ ({CRC_POLY[CRC_WIDTH-1:1], 1'b0} & {CRC_WIDTH{fb}});
    end
    return crc;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    at_last     = (Beats == 1) ? 1'b1
                               : (state_q == StAccum && !sof && beat_cnt_q == LastBeat);
    complete    = data_vld && ((Beats == 1) ? sof : at_last);
    crc_nxt     = crc_beat(sof ? '0 : crc_q, data_in, at_last);
    hdr_cur     = sof ? data_in[DWIDTH-1 -: 2] : hdr_q;
    crc_ok      = data_in[CRC_WIDTH-1:0] == (crc_nxt ^ CRC_WIDTH'(frame_id_q));
    rollback_id = thresh_q - Rollback;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      beat_cnt_q   <= '0;
      crc_q        <= '0;
      hdr_q        <= '0;
      frame_id_q   <= '0;
      thresh_q     <= '0;
      frame_done   <= 1'b0;
      frame_isdata <= 1'b0;
      frame_good   <= 1'b0;
      rx_error     <= 1'b0;
      retrans_req  <= 1'b0;
      retrans_id   <= '0;
      good_cnt     <= '0;
      err_cnt      <= '0;
      abort_cnt    <= '0;
    end else begin
      frame_done   <= 1'b0;
      frame_isdata <= 1'b0;
      frame_good   <= 1'b0;
      retrans_req  <= 1'b0;
      if (complete) begin
        state_q    <= StIdle;
        frame_done <= 1'b1;
        if (hdr_cur == 2'b01) begin
          frame_isdata <= 1'b1;
          if (crc_ok) begin
            // A good frame below the threshold is a replay: advance the ID, deliver nothing.
            frame_id_q <= frame_id_q + FRAME_ID_WIDTH'(1);
            if (frame_id_q == thresh_q) begin
              frame_good <= 1'b1;
              thresh_q   <= thresh_q + FRAME_ID_WIDTH'(1);
              rx_error   <= 1'b0;
              good_cnt   <= sat_inc(good_cnt);
            end
          end else begin
            frame_id_q  <= rollback_id;
            rx_error    <= 1'b1;
            retrans_req <= 1'b1;
            retrans_id  <= rollback_id;
            err_cnt     <= sat_inc(err_cnt);
          end
        end
      end else if (data_vld && sof) begin
        if (state_q == StAccum) abort_cnt <= sat_inc(abort_cnt);
        state_q    <= StAccum;
        beat_cnt_q <= BcW'(1);
        crc_q      <= crc_nxt;
        hdr_q      <= hdr_cur;
      end else if (data_vld && state_q == StAccum) begin
        beat_cnt_q <= beat_cnt_q + BcW'(1);
        crc_q      <= crc_nxt;
      end
    end
  end

endmodule

// File: doc/rifl_rx_frame_checker.md
Name: rifl_rx_frame_checker

Overview:
- Parametrised successor of the RIFL RX CRC/frame-ID validator.
- Accepts descrambled frames as DWIDTH-bit beats with a valid strobe. FRAME_WIDTH must be an integer multiple of DWIDTH, ratio 1 included.
- Checks the frame-ID-salted CRC and tracks the expected/new-frame IDs with rollback. Issues a retransmission request on failure and keeps saturating statistics.
- Sits between the RX descrambler and the RX data FIFO / retransmit controller.

Parameters:
- FRAME_WIDTH, 256, frame size in bits; multiple of DWIDTH.
- DWIDTH, 64, beat width in bits.
- CRC_WIDTH, 12, CRC field width, located in the last beat's LSBs.
- CRC_POLY, 12'h02F, polynomial in normal representation (x^CRC_WIDTH implicit).
- FRAME_ID_WIDTH, 8, frame ID width; must be <= CRC_WIDTH.
- ROLLBACK, 16, frames rewound on CRC failure; must be < 2^FRAME_ID_WIDTH.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- data_vld  in  1  beat valid
- sof  in  1  first beat of frame; qualified by data_vld
- data_in  in  DWIDTH  beat; sync header in [DWIDTH-1-:2] of the first beat
- frame_done  out  1  pulse: a complete frame was checked
- frame_isdata  out  1  valid with frame_done: header was 2'b01
- frame_good  out  1  pulse: new data frame accepted (CRC ok and ID == threshold)
- rx_error  out  1  level: in recovery after a CRC failure
- retrans_req  out  1  pulse: request retransmission
- retrans_id  out  FRAME_ID_WIDTH  ID to resume from; valid with retrans_req
- good_cnt  out  CNT_WIDTH  saturating count of frame_good pulses
- err_cnt  out  CNT_WIDTH  saturating count of CRC failures
- abort_cnt  out  CNT_WIDTH  saturating count of aborted frames

Behaviour:
- Reset (async): all outputs 0; frame_id = 0; threshold = 0; FSM in IDLE.
- FSM states:
  - IDLE → ACCUM on data_vld && sof when beats per frame > 1. When beats per frame = 1, the frame is checked immediately instead.
  - In ACCUM, a beat counter advances on each data_vld. The frame completes on beat FRAME_WIDTH/DWIDTH-1.
  - Completion → CHECK results registered; FSM returns to IDLE.
- Header 2'b01 marks a data frame. Any other header makes a non-data frame: it is consumed, no CRC check, frame_done=1, frame_isdata=0, no ID or statistics change.
- CRC computation:
  - Bit-serial MSB-first over all frame bits, seed 0, with the last CRC_WIDTH bits replaced by 0.
  - Per bit: fb = crc[MSB] ^ bit; crc = {crc[MSB-1:0], fb} ^ (POLY & {CRC_WIDTH{fb}}) on bits 1..MSB, with bit0 = fb.
  - The running CRC is kept across beats.
- CRC check: good iff received field == crc ^ zero-extended frame_id.
- Outputs are registered one cycle after the last beat is accepted.
- ID rules on a data frame (all arithmetic modulo 2^FRAME_ID_WIDTH):
  - CRC good and frame_id == threshold: frame_good=1; frame_id++, threshold++; rx_error cleared; good_cnt++.
  - CRC good and frame_id != threshold (replay of an already-delivered frame): frame_id++ only; no frame_good.
  - CRC bad: frame_id <= threshold - ROLLBACK; rx_error=1; retrans_req=1 with retrans_id = threshold - ROLLBACK; err_cnt++.
  - Every CRC failure, including one during recovery, re-issues retrans_req.
- Mid-frame sof (in ACCUM): the partial frame is discarded with no frame_done; abort_cnt++; a new frame starts from this beat.
- data_vld=0: no state change; gaps within a frame are allowed.
- Beats with data_vld=1 and sof=0 in IDLE are dropped silently.
- Counters saturate at all-ones.
- Reset mid-frame discards the partial frame with no outputs.

Test Plan:
- 4 good data frames with IDs 0..3 (default params, 4 beats each, back-to-back) → 4 frame_good pulses, each 1 cycle after beat 3; good_cnt=4; threshold=4.
- Frames ID0..ID19 good, then ID20 with one flipped payload bit → retrans_req with retrans_id=4; rx_error=1; err_cnt=1; frame_id=4.
- Continue from the previous case: resend IDs 4..20 correctly → no frame_good for 4..19; frame_good on 20; rx_error falls in the same cycle.
- sof asserted again at beat 2, then a full good frame → abort_cnt=1; exactly one frame_done; frame_good=1.
- Control frame (header 2'b10) between data frames, plus data_vld gaps of 3 cycles inside a frame → frame_done with frame_isdata=0; IDs unaffected; data frame still good.
- DWIDTH=FRAME_WIDTH=64 build; threshold starting at 250; 10 good frames → IDs wrap 255→0; frame_good every frame; inject a failure at threshold 2 → retrans_id=242.
